// File: rtl/cipher_stream_ctrl_if.sv
// Handshake bundle between the cipher stream controller and its neighbours.
// Byte streams, cipher issue/return channels and the current key.
interface cipher_stream_ctrl_if #(
  parameter int BLOCK_W = 96,
  parameter int KEY_W = 96
);
  logic [7:0] s_axis_tdata;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [BLOCK_W-1:0] c_tdata;
  logic c_mode;
  logic c_tvalid;
  logic c_tready;
  logic [KEY_W-1:0] key;
  logic [BLOCK_W-1:0] r_tdata;
  logic r_tvalid;
  logic r_tready;

  modport slave (
    input s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input m_axis_tready,
    output c_tdata, c_mode, c_tvalid,
    input c_tready,
    output key,
    input r_tdata, r_tvalid,
    output r_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    input s_axis_tready,
    input m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input c_tdata, c_mode, c_tvalid,
    output c_tready,
    input key,
    output r_tdata, r_tvalid,
    input r_tready
  );
endinterface

// File: rtl/cipher_stream_ctrl.sv
// Byte-stream command front end for a block cipher pipeline.
// Frames E/D/K commands, issues blocks, serialises results, drains on key change.
module cipher_stream_ctrl #(
  parameter int BLOCK_W = 96,
  parameter int KEY_W = 96,
  parameter logic [KEY_W-1:0] KEY_RESET = 96'h0123456789ABCDEF11112222,
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input logic clk,
  input logic rst_n,
  cipher_stream_ctrl_if.slave bus
);
  localparam int NB = BLOCK_W / 8;
  localparam int NK = KEY_W / 8;
  localparam int MAXN = (NB > NK) ? NB : NK;
  localparam int CW = $clog2(MAXN + 1);
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ?
    $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_K = 8'h4B;
  localparam logic [7:0] ST_BAD = 8'h3F;
  localparam logic [7:0] ST_OK = 8'h2B;
  localparam logic [7:0] ST_TMO = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    COL_BLK,
    COL_KEY,
    ISSUE,
    KEY_WAIT,
    STATUS
  } state_t;

  state_t state;
  logic live;
  logic mode_q;
  logic [BLOCK_W-1:0] blk;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] key_q;
  logic [CW-1:0] rx_cnt;
  logic [TW-1:0] tcnt;
  logic [FW-1:0] fly;
  logic [BLOCK_W-1:0] sreg;
  logic [CW-1:0] tx_cnt;
  logic ser_vld;
  logic st_vld;
  logic [7:0] st_code;

  logic s_hs;
  logic c_hs;
  logic r_hs;
  logic m_hs;
  logic in_col;
  logic t_exp;
  logic is_e;
  logic is_d;
  logic is_k;
  logic drained;
  logic [7:0] din;

  assign din = bus.s_axis_tdata;
  assign is_e = (din == CMD_E);
  assign is_d = (din == CMD_D);
  assign is_k = (din == CMD_K);

  assign in_col = (state == COL_BLK) ||
    (state == COL_KEY);

  assign bus.s_axis_tready = live &&
    ((state == IDLE) || in_col);
  assign bus.c_tvalid = (state == ISSUE) &&
    (fly != FW'(MAX_INFLIGHT));
  assign bus.c_tdata = blk;
  assign bus.c_mode = mode_q;
  assign bus.key = key_q;
  assign bus.r_tready = live && !ser_vld && !st_vld;
  assign bus.m_axis_tvalid = ser_vld || st_vld;
  assign bus.m_axis_tdata = st_vld ? st_code :
    sreg[BLOCK_W-1 -: 8];

  assign s_hs = bus.s_axis_tvalid && bus.s_axis_tready;
  assign c_hs = bus.c_tvalid && bus.c_tready;
  assign r_hs = bus.r_tvalid && bus.r_tready;
  assign m_hs = bus.m_axis_tvalid && bus.m_axis_tready;

  // Nothing in the cipher and nothing left to send.
  assign drained = (fly == '0) && !ser_vld;

  assign t_exp = (TIMEOUT_CYC > 0) && in_col && !s_hs &&
    (tcnt == TW'(TIMEOUT_CYC - 1));

  // Idle-cycle timer inside a partially received frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (in_col && !s_hs) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  // Command framing, block issue and key handover
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      mode_q <= 1'b0;
      blk <= '0;
      shadow <= '0;
      key_q <= KEY_RESET;
      rx_cnt <= '0;
      st_vld <= 1'b0;
      st_code <= '0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (s_hs) begin
            rx_cnt <= '0;
            unique case (1'b1)
              is_e, is_d: begin
                state <= COL_BLK;
                mode_q <= is_d;
              end
              is_k: state <= COL_KEY;
              default: begin
                state <= STATUS;
                st_code <= ST_BAD;
              end
            endcase
          end
        end
        COL_BLK: begin
          if (t_exp) begin
            state <= STATUS;
            st_code <= ST_TMO;
          end else if (s_hs) begin
            blk <= {blk[BLOCK_W-9:0], din};
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == CW'(NB - 1)) state <= ISSUE;
          end
        end
        COL_KEY: begin
          if (t_exp) begin
            state <= STATUS;
            st_code <= ST_TMO;
          end else if (s_hs) begin
            shadow <= {shadow[KEY_W-9:0], din};
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == CW'(NK - 1)) state <= KEY_WAIT;
          end
        end
        ISSUE: begin
          if (c_hs) state <= IDLE;
        end
        KEY_WAIT: begin
          if (drained) begin
            key_q <= shadow;
            state <= STATUS;
            st_code <= ST_OK;
          end
        end
        STATUS: begin
          if (st_vld) begin
            if (m_hs) begin
              st_vld <= 1'b0;
              state <= IDLE;
            end
          end else if (drained) begin
            st_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blocks issued to the cipher and not yet returned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fly <= '0;
    end else if (c_hs && !r_hs) begin
      fly <= fly + 1'b1;
    end else if (r_hs && !c_hs && (fly != '0)) begin
      fly <= fly - 1'b1;
    end
  end

  // Result serializer, MSByte first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_vld <= 1'b0;
      sreg <= '0;
      tx_cnt <= '0;
    end else if (r_hs) begin
      sreg <= bus.r_tdata;
      tx_cnt <= '0;
      ser_vld <= 1'b1;
    end else if (ser_vld && bus.m_axis_tready) begin
      sreg <= {sreg[BLOCK_W-9:0], 8'h00};
      tx_cnt <= tx_cnt + 1'b1;
      if (tx_cnt == CW'(NB - 1)) ser_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl: frame-level model, cipher emulator, compare.
// Runs with MAX_INFLIGHT=2 and TIMEOUT_CYC=16.
module tb_cipher_stream_ctrl;
  localparam int BW = 96;
  localparam int KW = 96;
  localparam int NB = 12;
  localparam int MAXF = 2;
  localparam int TO = 16;
  localparam logic [95:0] KRST = 96'h0123456789ABCDEF11112222;
  localparam logic [95:0] KNEW = 96'hA1B2C3D4E5F60718293A4B5C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cipher_stream_ctrl_if #(.BLOCK_W(BW), .KEY_W(KW)) bus();

  cipher_stream_ctrl #(
    .BLOCK_W(BW),
    .KEY_W(KW),
    .KEY_RESET(KRST),
    .MAX_INFLIGHT(MAXF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [95:0] d;
    logic m;
  } cexp_t;

  typedef struct {
    logic [7:0] b;
    logic [95:0] k;
  } mexp_t;

  int vectors = 0;
  int miscompares = 0;

  cexp_t exp_c[$];
  mexp_t exp_m[$];
  logic [95:0] pend[$];
  logic [7:0] m_log[$];
  logic [95:0] mkey = KRST;
  logic [95:0] last_c = '0;
  logic last_mode = 1'b0;

  bit xform = 1'b0;
  bit hold_r = 1'b0;
  bit r_slow = 1'b0;
  bit c_slow = 1'b0;
  bit m_slow = 1'b0;
  bit m_hold = 1'b0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout want completion", nm);
  endtask

  // ---- model: what each frame must produce ----
  task automatic model_block(input bit dec, input logic [95:0] d);
    cexp_t e;
    mexp_t mm;
    logic [95:0] r;
    e.d = d;
    e.m = dec;
    exp_c.push_back(e);
    r = d ^ (xform ? mkey : 96'h0);
    for (int i = 0; i < NB; i++) begin
      mm.b = r[95-8*i -: 8];
      mm.k = mkey;
      exp_m.push_back(mm);
    end
  endtask

  task automatic model_status(input logic [7:0] code);
    mexp_t mm;
    mm.b = code;
    mm.k = mkey;
    exp_m.push_back(mm);
  endtask

  task automatic model_key(input logic [95:0] k);
    mkey = k;
    model_status(8'h2B);
  endtask

  // ---- stimulus ----
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_axis_tdata = b;
    bus.s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_axis_tready) break;
      n++;
      if (n > 3000) begin
        fail_bound("s_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_blk(input bit dec, input logic [95:0] d);
    model_block(dec, d);
    send_byte(dec ? 8'h44 : 8'h45);
    for (int i = 0; i < NB; i++) send_byte(d[95-8*i -: 8]);
  endtask

  task automatic send_key(input logic [95:0] k);
    model_key(k);
    send_byte(8'h4B);
    for (int i = 0; i < NB; i++) send_byte(k[95-8*i -: 8]);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_c.size() == 0 && exp_m.size() == 0 &&
          pend.size() == 0 && !bus.m_axis_tvalid &&
          !bus.c_tvalid) break;
      n++;
      if (n > 3000) begin
        fail_bound(nm);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_c.delete();
    exp_m.delete();
    mkey = KRST;
    #1;
    check("rst_c_tvalid", bus.c_tvalid, 1'b0);
    check("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst_s_tready", bus.s_axis_tready, 1'b0);
    check("rst_r_tready", bus.r_tready, 1'b0);
    check("rst_key", bus.key, KRST);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---- cipher and sink emulation ----
  initial begin : cipher_emu
    bit chs;
    bit rhs;
    logic [95:0] cd;
    logic [95:0] kk;
    int cyc;
    int rwait;
    cyc = 0;
    rwait = 0;
    bus.c_tready = 1'b0;
    bus.r_tvalid = 1'b0;
    bus.r_tdata = '0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      chs = bus.c_tvalid && bus.c_tready;
      cd = bus.c_tdata;
      kk = bus.key;
      rhs = bus.r_tvalid && bus.r_tready;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pend.delete();
        bus.r_tvalid = 1'b0;
        rwait = 0;
      end else begin
        if (chs) pend.push_back(cd ^ (xform ? kk : 96'h0));
        if (rhs) begin
          void'(pend.pop_front());
          bus.r_tvalid = 1'b0;
          rwait = r_slow ? 3 : 0;
        end
        if (!bus.r_tvalid && pend.size() > 0 && !hold_r) begin
          if (rwait > 0) begin
            rwait--;
          end else begin
            bus.r_tvalid = 1'b1;
            bus.r_tdata = pend[0];
          end
        end
      end
      bus.c_tready = c_slow ? (cyc % 3 == 0) : 1'b1;
      bus.m_axis_tready = m_hold ? 1'b0 :
        (m_slow ? (cyc % 2 == 0) : 1'b1);
    end
  end

  // ---- compare DUT outputs against the model every cycle ----
  initial begin : compare
    cexp_t ce;
    mexp_t me;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.r_tvalid)
          assert (pend.size() > 0)
            else $error("r_tvalid with nothing in flight");
        if (bus.c_tvalid)
          check("c_inflight_limit", pend.size() < MAXF, 1'b1);
        if (bus.c_tvalid && bus.c_tready) begin
          last_c = bus.c_tdata;
          last_mode = bus.c_mode;
          if (exp_c.size() == 0) begin
            check("c_unexpected", bus.c_tdata, 96'hx);
          end else begin
            ce = exp_c.pop_front();
            check("c_tdata", bus.c_tdata, ce.d);
            check("c_mode", bus.c_mode, ce.m);
          end
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          m_log.push_back(bus.m_axis_tdata);
          if (exp_m.size() == 0) begin
            check("m_unexpected", bus.m_axis_tdata, 8'hx);
          end else begin
            me = exp_m.pop_front();
            check("m_byte", bus.m_axis_tdata, me.b);
            check("key_at_m", bus.key, me.k);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---- directed sequence ----
  initial begin : main
    int n;
    logic [7:0] acc;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_s_tready", bus.s_axis_tready, 1'b1);
    check("post_rst_r_tready", bus.r_tready, 1'b1);

    // Plain loopback encrypt frame
    m_log.delete();
    send_blk(1'b0, 96'h000102030405060708090A0B);
    check("issue_c_tvalid", bus.c_tvalid, 1'b1);
    check("issue_s_tready", bus.s_axis_tready, 1'b0);
    wait_drain("drain_e1");
    check("e1_c_lit", last_c, 96'h000102030405060708090A0B);
    check("e1_mode_lit", last_mode, 1'b0);
    check("e1_m_count", m_log.size(), NB);
    for (int i = 0; i < NB; i++)
      if (i < m_log.size()) check("e1_m_lit", m_log[i], i);

    // Unknown command, then decrypt frame
    m_log.delete();
    model_status(8'h3F);
    send_byte(8'h5A);
    wait_drain("drain_bad");
    check("bad_count", m_log.size(), 1);
    if (m_log.size() > 0) check("bad_lit", m_log[0], 8'h3F);
    xform = 1'b1;
    m_log.delete();
    send_blk(1'b1, 96'hFEDCBA9876543210A5A55A5A);
    wait_drain("drain_d1");
    check("d1_mode_lit", last_mode, 1'b1);
    if (m_log.size() > 0) check("d1_m0_lit", m_log[0], 8'hFF);

    // Key load while two blocks are held in the cipher
    m_log.delete();
    hold_r = 1'b1;
    c_slow = 1'b1;
    send_blk(1'b0, 96'h111111112222222233333333);
    send_blk(1'b0, 96'h0F1E2D3C4B5A69788796A5B4);
    send_key(KNEW);
    repeat (20) @(posedge clk);
    #1;
    check("kw_key_old", bus.key, KRST);
    check("kw_s_tready", bus.s_axis_tready, 1'b0);
    r_slow = 1'b1;
    m_slow = 1'b1;
    hold_r = 1'b0;
    wait_drain("drain_key");
    check("key_new_lit", bus.key, KNEW);
    check("key_m_count", m_log.size(), 2 * NB + 1);
    if (m_log.size() > 0)
      check("key_plus_last", m_log[m_log.size()-1], 8'h2B);
    c_slow = 1'b0;
    r_slow = 1'b0;
    m_slow = 1'b0;

    // In-flight limit with results held back
    hold_r = 1'b1;
    send_blk(1'b0, 96'hAAAAAAAABBBBBBBBCCCCCCCC);
    send_blk(1'b1, 96'h123456789ABCDEF012345678);
    send_blk(1'b0, 96'h00000000FFFFFFFF00000000);
    check("lim_c_tvalid0", bus.c_tvalid, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("lim_c_tvalid1", bus.c_tvalid, 1'b0);
    check("lim_s_tready", bus.s_axis_tready, 1'b0);
    check("lim_pending", pend.size(), MAXF);
    hold_r = 1'b0;
    wait_drain("drain_lim");

    // Timeout on a partial frame
    m_log.delete();
    model_status(8'h21);
    send_byte(8'h45);
    for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i));
    repeat (14) @(posedge clk);
    #1;
    check("tmo_early_m", bus.m_axis_tvalid, 1'b0);
    check("tmo_early_s", bus.s_axis_tready, 1'b1);
    wait_drain("drain_tmo");
    check("tmo_count", m_log.size(), 1);
    if (m_log.size() > 0) check("tmo_lit", m_log[0], 8'h21);
    send_blk(1'b0, 96'h5555555566666666777777AA);
    wait_drain("drain_post_tmo");

    // Reset mid-frame and mid-serialise
    send_byte(8'h45);
    for (int i = 0; i < 3; i++) send_byte(8'h10);
    do_reset();
    m_hold = 1'b1;
    send_blk(1'b0, 96'hCAFEBABEDEADBEEF01020304);
    n = 0;
    while (!bus.m_axis_tvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_bound("m_valid_wait");
    do_reset();
    m_hold = 1'b0;
    m_log.delete();
    send_blk(1'b0, KRST);
    wait_drain("drain_post_rst");
    check("rst_frame_count", m_log.size(), NB);
    acc = '0;
    foreach (m_log[i]) acc = acc | m_log[i];
    check("rst_frame_zero", acc, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
